// File: rtl/featuremap_pad_writer_if.sv
// Stream bundle between the featuremap source, the pad writer and the
// downstream channel FIFO.
interface featuremap_pad_writer_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  valid_in;
  logic                  fifo_full;
  logic                  wrreq;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  frame_done;
  logic                  overflow;

  modport master (
    output data_in,
    output valid_in,
    output fifo_full,
    input  wrreq,
    input  data_out,
    input  frame_done,
    input  overflow
  );

  modport slave (
    input  data_in,
    input  valid_in,
    input  fifo_full,
    output wrreq,
    output data_out,
    output frame_done,
    output overflow
  );
endinterface

// File: rtl/featuremap_pad_writer.sv
// Buffers an unpadded raster featuremap and writes it out wrapped in a
// one-pixel border of +0.0 words, one word per non-stalled cycle.
module featuremap_pad_writer #(
  parameter int DATA_WIDTH = 32,
  parameter int WIDTH      = 56,
  parameter int BUF_DEPTH  = 256
) (
  input logic                   clk,
  input logic                   rst,
  featuremap_pad_writer_if.slave io
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] PIX  = CW'(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH + 1);
  localparam logic [AW:0]   FULL = (AW + 1)'(BUF_DEPTH);

  typedef enum logic [2:0] {
    IDLE, TOP, LEFT, BODY, RIGHT, BOTTOM
  } state_t;

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count;
  logic                  empty;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  drop;

  state_t                state, state_n;
  logic [CW-1:0]         r, r_n;
  logic [CW-1:0]         c, c_n;
  logic                  emit;
  logic                  last;
  logic [DATA_WIDTH-1:0] word;

  logic                  wrreq;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  frame_done;
  logic                  overflow;

  assign empty = (count == '0);
  assign full  = (count == FULL);
  // A pop in the same cycle frees the slot, so a full buffer still accepts.
  assign push  = !rst && io.valid_in && (!full || pop);
  assign drop  = !rst && io.valid_in && full && !pop;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= io.data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      r     <= '0;
      c     <= '0;
    end else begin
      state <= state_n;
      r     <= r_n;
      c     <= c_n;
    end
  end

  always_comb begin
    state_n = state;
    r_n     = r;
    c_n     = c;
    emit    = 1'b0;
    last    = 1'b0;
    pop     = 1'b0;
    word    = '0;
    if (!io.fifo_full) begin
      unique case (state)
        IDLE: begin
          if (!empty) begin
            state_n = TOP;
            r_n     = '0;
            c_n     = '0;
          end
        end
        TOP: begin
          emit = 1'b1;
          if (c == LAST) begin
            state_n = LEFT;
            r_n     = CW'(1);
            c_n     = '0;
          end else begin
            c_n = c + 1'b1;
          end
        end
        LEFT: begin
          emit    = 1'b1;
          state_n = BODY;
          c_n     = CW'(1);
        end
        BODY: begin
          if (!empty) begin
            emit = 1'b1;
            pop  = 1'b1;
            word = mem[rd_ptr];
            if (c == PIX) begin
              state_n = RIGHT;
              c_n     = LAST;
            end else begin
              c_n = c + 1'b1;
            end
          end
        end
        RIGHT: begin
          emit = 1'b1;
          c_n  = '0;
          if (r < PIX) begin
            state_n = LEFT;
            r_n     = r + 1'b1;
          end else begin
            state_n = BOTTOM;
            r_n     = LAST;
          end
        end
        BOTTOM: begin
          emit = 1'b1;
          if (c == LAST) begin
            last    = 1'b1;
            r_n     = '0;
            c_n     = '0;
            // Roll straight into the next frame when pixels are waiting.
            state_n = empty ? IDLE : TOP;
          end else begin
            c_n = c + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrreq      <= 1'b0;
      data_out   <= '0;
      frame_done <= 1'b0;
    end else begin
      wrreq      <= emit;
      frame_done <= last;
      if (emit) begin
        data_out <= word;
      end
    end
  end

  assign io.wrreq      = wrreq;
  assign io.data_out   = data_out;
  assign io.frame_done = frame_done;
  assign io.overflow   = overflow;

endmodule

// File: tb/tb_featuremap_pad_writer.sv
// Bench for featuremap_pad_writer: table-driven and randomized runs
// scored against a padded-frame reference model.
module tb_featuremap_pad_writer;

  localparam int W     = 2;
  localparam int DEPTH = 16;
  localparam int FW    = (W + 2) * (W + 2);

  typedef struct {
    int nframes;
    int rnd;
    int gap_lo;
    int gap_hi;
    int ff_pct;
    int exp_writes;
    int exp_done;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  featuremap_pad_writer_if #(.DATA_WIDTH(32)) io ();

  featuremap_pad_writer #(
    .DATA_WIDTH(32),
    .WIDTH     (W),
    .BUF_DEPTH (DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (io)
  );

  always #5 clk = ~clk;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] got_d[$];
  logic        got_f[$];
  logic [31:0] pix_q[$];
  logic [31:0] exp_q[$];
  logic        ff_s;
  logic        drv_done;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h need %0h", name, got, exp);
    end
  endtask

  always @(posedge clk) begin
    ff_s = io.fifo_full;
    #1;
    if (ff_s) chk("stall_wrreq", 32'(io.wrreq), 32'd0);
    if (io.frame_done) chk("done_wrreq", 32'(io.wrreq), 32'd1);
    if (io.wrreq) begin
      got_d.push_back(io.data_out);
      got_f.push_back(io.frame_done);
    end
  end

  // Reference: every W*W pixels form one frame framed by zero words.
  function automatic void build_exp();
    int nf;
    exp_q.delete();
    nf = pix_q.size() / (W * W);
    for (int f = 0; f < nf; f++)
      for (int rr = 0; rr < W + 2; rr++)
        for (int cc = 0; cc < W + 2; cc++)
          if (rr == 0 || cc == 0 || rr == W + 1 || cc == W + 1)
            exp_q.push_back(32'd0);
          else
            exp_q.push_back(pix_q[f*W*W + (rr-1)*W + (cc-1)]);
  endfunction

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    io.valid_in = 1'b0;
    io.fifo_full = 1'b0;
    io.data_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    got_d.delete();
    got_f.delete();
    pix_q.delete();
  endtask

  task automatic send(input logic [31:0] v, input int gap);
    @(negedge clk);
    io.valid_in = 1'b1;
    io.data_in  = v;
    pix_q.push_back(v);
    repeat (gap) begin
      @(negedge clk);
      io.valid_in = 1'b0;
    end
  endtask

  task automatic idle_in();
    @(negedge clk);
    io.valid_in = 1'b0;
  endtask

  task automatic check_run(input string name, input int exp_n,
                           input int exp_done);
    int t = 0;
    int nd = 0;
    int n;
    build_exp();
    chk({name, "_model_len"}, 32'(exp_q.size()), 32'(exp_n));
    while (got_d.size() < exp_q.size() && t < 3000) begin
      @(posedge clk);
      t++;
    end
    repeat (30) @(posedge clk);
    #2;
    chk({name, "_count"}, 32'(got_d.size()), 32'(exp_q.size()));
    n = (got_d.size() < exp_q.size()) ? got_d.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_word%0d", name, i), got_d[i], exp_q[i]);
      chk($sformatf("%s_done%0d", name, i), 32'(got_f[i]),
          32'(((i + 1) % FW) == 0));
      if (got_f[i]) nd++;
    end
    chk({name, "_ndone"}, 32'(nd), 32'(exp_done));
  endtask

  task automatic run_row(input vec_t v, input int idx);
    reset_dut();
    drv_done = 1'b0;
    fork
      begin
        for (int i = 0; i < v.nframes * W * W; i++)
          send(v.rnd != 0 ? $urandom : 32'(i + 1),
               $urandom_range(v.gap_hi, v.gap_lo));
        idle_in();
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          @(negedge clk);
          io.fifo_full = ($urandom_range(99, 0) < 32'(v.ff_pct));
        end
        io.fifo_full = 1'b0;
      end
    join
    check_run($sformatf("row%0d", idx), v.exp_writes, v.exp_done);
    chk($sformatf("row%0d_ovf", idx), 32'(io.overflow), 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  vec_t tbl[6];

  initial begin
    int t;
    tbl[0] = '{1, 0, 0, 0, 0, 16, 1};
    tbl[1] = '{1, 0, 9, 9, 0, 16, 1};
    tbl[2] = '{2, 0, 0, 0, 0, 32, 2};
    tbl[3] = '{3, 1, 4, 10, 25, 48, 3};
    tbl[4] = '{4, 1, 6, 12, 40, 64, 4};
    tbl[5] = '{2, 1, 0, 0, 0, 32, 2};

    io.valid_in  = 1'b0;
    io.fifo_full = 1'b0;
    io.data_in   = '0;
    reset_dut();
    #1;
    chk("rst_wrreq", 32'(io.wrreq), 32'd0);
    chk("rst_data", io.data_out, 32'd0);
    chk("rst_done", 32'(io.frame_done), 32'd0);
    chk("rst_ovf", 32'(io.overflow), 32'd0);

    for (int i = 0; i < 6; i++) run_row(tbl[i], i);

    // Output stalled for five cycles inside the first body row.
    reset_dut();
    fork
      begin
        for (int i = 1; i <= 4; i++) send(32'(i), 0);
        idle_in();
      end
      begin
        int tt = 0;
        while (got_d.size() < 6 && tt < 500) begin
          @(negedge clk);
          tt++;
        end
        io.fifo_full = 1'b1;
        repeat (5) @(negedge clk);
        io.fifo_full = 1'b0;
      end
    join
    check_run("stall", 16, 1);

    // Two-cycle latency into an empty body.
    reset_dut();
    send(32'd1, 0);
    idle_in();
    t = 0;
    while (got_d.size() < 5 && t < 500) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    io.valid_in = 1'b1;
    io.data_in  = 32'd2;
    pix_q.push_back(32'd2);
    @(negedge clk);
    io.valid_in = 1'b0;
    chk("lat_t1_wrreq", 32'(io.wrreq), 32'd0);
    @(posedge clk);
    #1;
    chk("lat_t2_wrreq", 32'(io.wrreq), 32'd1);
    chk("lat_t2_data", io.data_out, 32'd2);
    send(32'd3, 0);
    send(32'd4, 0);
    idle_in();
    check_run("latency", 16, 1);

    // Overflow with the output blocked.
    reset_dut();
    @(negedge clk);
    io.fifo_full = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      if (i == 17) chk("ovf_before", 32'(io.overflow), 32'd0);
      io.valid_in = 1'b1;
      io.data_in  = 32'(i);
      if (i <= 16) pix_q.push_back(32'(i));
    end
    @(negedge clk);
    io.valid_in = 1'b0;
    chk("ovf_set", 32'(io.overflow), 32'd1);
    repeat (5) @(negedge clk);
    chk("ovf_hold", 32'(io.overflow), 32'd1);
    io.fifo_full = 1'b0;
    check_run("ovf_frames", 64, 4);
    chk("ovf_sticky", 32'(io.overflow), 32'd1);
    reset_dut();
    #1;
    chk("ovf_clear", 32'(io.overflow), 32'd0);

    // Reset after the seventh write of a frame.
    reset_dut();
    for (int i = 1; i <= 4; i++) send(32'(i), 0);
    idle_in();
    t = 0;
    while (got_d.size() < 7 && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("mid_reached7", 32'(got_d.size()), 32'd7);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_wrreq", 32'(io.wrreq), 32'd0);
    chk("mid_ovf", 32'(io.overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("mid_quiet", 32'(got_d.size()), 32'd7);
    got_d.delete();
    got_f.delete();
    pix_q.delete();
    for (int i = 5; i <= 8; i++) send(32'(i), 0);
    idle_in();
    check_run("mid_fresh", 16, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/featuremap_pad_writer.md
FEATUREMAP_PAD_WRITER -- requirements
Module: featuremap_pad_writer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of one pixel word (IEEE-754 single).
REQ-002 SHALL have parameter WIDTH, default 56: unpadded frame side length; the padded frame is (WIDTH+2) x (WIDTH+2).
REQ-003 SHALL have parameter BUF_DEPTH, default 256: input buffer depth in words; power of two; at least 4*WIDTH+8.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port data_in, input, DATA_WIDTH bits: unpadded raster pixel from the upstream featuremap data_out.
REQ-007 SHALL have port valid_in, input, 1 bit: data_in is valid this cycle; there is no backpressure to upstream.
REQ-008 SHALL have port fifo_full, input, 1 bit: the downstream channel FIFO cannot accept a write.
REQ-009 SHALL have port wrreq, output, 1 bit: write strobe to the channel FIFO.
REQ-010 SHALL have port data_out, output, DATA_WIDTH bits: padded-frame word, valid while wrreq=1.
REQ-011 SHALL have port frame_done, output, 1 bit: one-cycle pulse with the last word of a padded frame.
REQ-012 SHALL have port overflow, output, 1 bit: sticky flag marking an input word dropped because the buffer was full.

Function
REQ-013 SHALL push data_in into an internal FIFO buffer of BUF_DEPTH words on every cycle with valid_in=1 and the buffer not full.
REQ-014 SHALL drop data_in when valid_in=1 and the buffer is full, and SHALL set overflow=1 until rst.
REQ-015 SHALL, when push and pop occur in the same cycle, perform both and leave the occupancy unchanged, including at full and at empty+push.
REQ-016 SHALL implement the FSM states IDLE, TOP, LEFT, BODY, RIGHT and BOTTOM, with row counter r and column counter c, each 0..WIDTH+1.
REQ-017 SHALL transition IDLE->TOP when the buffer is non-empty, with r=0 and c=0.
REQ-018 SHALL emit word (r,c) only in a cycle with fifo_full=0; in any cycle with fifo_full=1 the state, counters and buffer head SHALL hold.
REQ-019 SHALL, in TOP, emit zeros for c=0..WIDTH+1, then go to LEFT with r=1.
REQ-020 SHALL, in LEFT, emit one zero (c=0), then go to BODY.
REQ-021 SHALL, in BODY, emit the buffer head and pop it for c=1..WIDTH; when the buffer is empty it SHALL emit nothing and stall, with no wrreq.
REQ-022 SHALL, in RIGHT, emit one zero (c=WIDTH+1); then go to LEFT with r+1 if r<WIDTH, otherwise to BOTTOM with r=WIDTH+1.
REQ-023 SHALL, in BOTTOM, emit zeros for c=0..WIDTH+1, then return to IDLE.
REQ-024 SHALL register wrreq and data_out: a word emitted in cycle t SHALL appear as wrreq=1 with data_out during cycle t+1; otherwise wrreq=0.
REQ-025 SHALL give a latency of 2 cycles from a valid_in that finds the FSM in BODY with an empty buffer and fifo_full=0 to the corresponding wrreq.
REQ-026 SHALL assert frame_done in the same cycle as the wrreq of word (WIDTH+1, WIDTH+1).
REQ-027 SHALL emit exactly (WIDTH+2)^2 words per frame, in raster order.
REQ-028 SHALL pass pixel bits unmodified, with padding words equal to all-zero bits (+0.0).
REQ-029 SHALL accept input words for the next frame while the current frame is still padding, and SHALL begin the next frame from IDLE without any idle cycle when the buffer is non-empty.

Reset
REQ-030 SHALL, on rst=1 at a clock edge: set the FSM to IDLE and r=c=0, empty the buffer, and drive wrreq=0, data_out=0, frame_done=0 and overflow=0.
REQ-031 SHALL discard any partially emitted frame on a mid-frame reset, with no further wrreq until new valid_in.
REQ-032 SHALL ignore valid_in in any cycle with rst=1.

Verification
REQ-033 SHALL cover: WIDTH=2, inputs 1,2,3,4 on consecutive cycles, fifo_full=0 -> 16 writes 0,0,0,0, 0,1,2,0, 0,3,4,0, 0,0,0,0, with frame_done on the 16th write.
REQ-034 SHALL cover: WIDTH=2, fifo_full=1 for 5 cycles mid-BODY -> no wrreq during the stall, identical 16-word sequence afterwards, nothing lost or duplicated.
REQ-035 SHALL cover: WIDTH=2, pixels spaced 10 cycles apart -> BODY stalls with wrreq=0 while the buffer is empty; output equals REQ-033.
REQ-036 SHALL cover: BUF_DEPTH=16, WIDTH=2, fifo_full held at 1, 17 inputs -> overflow=1 after the 17th input, stays 1 until rst, and the 17th word never appears.
REQ-037 SHALL cover: reset asserted after the 7th write -> wrreq=0 and overflow=0 next cycle; a fresh frame of inputs 5,6,7,8 yields a clean 16-word padded frame.
REQ-038 SHALL cover: two frames back-to-back (8 inputs, 1..8) -> 32 writes, frame_done exactly twice, and the second frame's interior is 5,6,7,8.
